// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU comparator front end.
//   OPERAND_W      - operand width (two's complement)
//   CMP_W          - width of the comparison select field
//   CMP_*          - comparison select encodings consumed by the comparator
//   loader_state_t - operand loader FSM states, also shown on the step LEDs
package alu_pkg;

  localparam int OPERAND_W = 6;
  localparam int CMP_W     = 2;

  localparam logic [CMP_W-1:0] CMP_EQ    = 2'b00;  // a == b
  localparam logic [CMP_W-1:0] CMP_GT    = 2'b01;  // a >  b
  localparam logic [CMP_W-1:0] CMP_LT    = 2'b10;  // a <  b
  localparam logic [CMP_W-1:0] CMP_AZERO = 2'b11;  // a == 0

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    READY   = 2'b11
  } loader_state_t;

endpackage

// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces one raw pushbutton.
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   btn_raw - raw, bouncy, asynchronous button input (active-high)
//   level   - debounced button level
//   press   - one-cycle pulse on each debounced 0->1 transition
// The debounced level follows the synchronized input only after the two have
// disagreed for DEBOUNCE_CYCLES consecutive clocks.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             level_d;

  // Stage boundary: 2-flop synchronizer, stability counter, edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      if (sync_p1 != level) begin
        // The final disagreeing cycle flips the level rather than counting on.
        if (cnt == CNT_LAST) begin
          level <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: captures operand A, operand B and a comparison select
// from the slide switches, one field per debounced load press.
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   sw           - raw slide switches (asynchronous, quasi-static)
//   btn_load     - raw load pushbutton (active-high, bouncy)
//   btn_clear    - raw clear pushbutton (active-high, bouncy)
//   a, b         - captured operands, two's complement, bit-exact
//   comparison   - captured comparison select (sw[1:0] at capture)
//   valid        - all three fields captured and unchanged
//   ready_strobe - one-cycle pulse in the first cycle valid reads 1
//   step         - current FSM state for the LEDs
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int OPERAND_W       = alu_pkg::OPERAND_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic        [OPERAND_W-1:0] sw,
  input  logic                        btn_load,
  input  logic                        btn_clear,
  output logic signed [OPERAND_W-1:0] a,
  output logic signed [OPERAND_W-1:0] b,
  output logic        [CMP_W-1:0]     comparison,
  output logic                        valid,
  output logic                        ready_strobe,
  output logic        [1:0]           step
);

  logic                        load_press;
  logic                        clear_press;
  logic                        load_level_unused;
  logic                        clear_level_unused;
  logic        [OPERAND_W-1:0] sw_p0;
  logic        [OPERAND_W-1:0] sw_p1;

  loader_state_t               state;
  loader_state_t               state_nx;
  logic signed [OPERAND_W-1:0] a_nx;
  logic signed [OPERAND_W-1:0] b_nx;
  logic        [CMP_W-1:0]     comparison_nx;
  logic                        valid_nx;
  logic                        ready_strobe_nx;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_load_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_load),
    .level   (load_level_unused),
    .press   (load_press)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_clear_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_clear),
    .level   (clear_level_unused),
    .press   (clear_press)
  );

  // Stage boundary: switch synchronizer; its second flop is what gets captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= sw;
      sw_p1 <= sw_p0;
    end
  end

  always_comb begin
    state_nx        = state;
    a_nx            = a;
    b_nx            = b;
    comparison_nx   = comparison;
    valid_nx        = valid;
    ready_strobe_nx = 1'b0;
    // Clear takes priority and swallows a coincident load press.
    if (clear_press) begin
      state_nx      = LOAD_A;
      a_nx          = '0;
      b_nx          = '0;
      comparison_nx = CMP_EQ;
      valid_nx      = 1'b0;
    end else if (load_press) begin
      case (state)
        LOAD_A: begin
          a_nx     = $signed(sw_p1);
          state_nx = LOAD_B;
        end
        LOAD_B: begin
          b_nx     = $signed(sw_p1);
          state_nx = LOAD_OP;
        end
        LOAD_OP: begin
          comparison_nx   = sw_p1[CMP_W-1:0];
          valid_nx        = 1'b1;
          ready_strobe_nx = 1'b1;
          state_nx        = READY;
        end
        READY: begin
          // Fields are kept; only the set is no longer complete.
          valid_nx = 1'b0;
          state_nx = LOAD_A;
        end
        default: state_nx = LOAD_A;
      endcase
    end
  end

  // Stage boundary: FSM state and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD_A;
      a            <= '0;
      b            <= '0;
      comparison   <= CMP_EQ;
      valid        <= 1'b0;
      ready_strobe <= 1'b0;
    end else begin
      state        <= state_nx;
      a            <= a_nx;
      b            <= b_nx;
      comparison   <= comparison_nx;
      valid        <= valid_nx;
      ready_strobe <= ready_strobe_nx;
    end
  end

  assign step = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
module tb_alu_operand_loader;

  logic       clk;
  logic       rst_n;
  logic [5:0] sw;
  logic       btn_load;
  logic       btn_clear;
  logic [5:0] a;
  logic [5:0] b;
  logic [1:0] comparison;
  logic       valid;
  logic       ready_strobe;
  logic [1:0] step;

  int n_checks = 0;
  int n_pass   = 0;
  int strobe_cnt = 0;
  int strobe_bad = 0;
  logic valid_prev = 1'b0;

  alu_operand_loader #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .btn_load     (btn_load),
    .btn_clear    (btn_clear),
    .a            (a),
    .b            (b),
    .comparison   (comparison),
    .valid        (valid),
    .ready_strobe (ready_strobe),
    .step         (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe must coincide exactly with valid rising.
  always @(negedge clk) begin
    if (ready_strobe) strobe_cnt++;
    if (ready_strobe != (valid && !valid_prev)) strobe_bad++;
    valid_prev = valid;
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_press(input logic [5:0] v, input logic ld, input logic cl);
    @(negedge clk);
    sw = v;
    btn_load = ld;
    btn_clear = cl;
    repeat (10) @(negedge clk);
    btn_load = 1'b0;
    btn_clear = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Raise btn_load just after a negedge, return posedge count until step moves.
  task automatic measure_latency(output int lat);
    logic [1:0] old;
    old = step;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (step != old) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    sw = 6'd0;
    btn_load = 1'b0;
    btn_clear = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_a", {2'b0, a}, 8'h00);
    check_eq("rst_b", {2'b0, b}, 8'h00);
    check_eq("rst_cmp", {6'b0, comparison}, 8'h00);
    check_eq("rst_valid", {7'b0, valid}, 8'h00);
    check_eq("rst_strobe", {7'b0, ready_strobe}, 8'h00);
    check_eq("rst_step", {6'b0, step}, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Three clean presses.
    do_press(6'b111011, 1'b1, 1'b0);
    check_eq("p1_step", {6'b0, step}, 8'h01);
    check_eq("p1_a", {2'b0, a}, 8'h3B);
    check_eq("p1_valid", {7'b0, valid}, 8'h00);
    do_press(6'b000101, 1'b1, 1'b0);
    check_eq("p2_step", {6'b0, step}, 8'h02);
    check_eq("p2_b", {2'b0, b}, 8'h05);
    do_press(6'b000001, 1'b1, 1'b0);
    check_eq("p3_step", {6'b0, step}, 8'h03);
    check_eq("p3_cmp", {6'b0, comparison}, 8'h01);
    check_eq("p3_valid", {7'b0, valid}, 8'h01);
    check_eq("p3_a", {2'b0, a}, 8'h3B);
    check_eq("strobe_cnt", strobe_cnt[7:0], 8'd1);

    // Press in READY: fields held, valid drops.
    do_press(6'b000111, 1'b1, 1'b0);
    check_eq("rdy_step", {6'b0, step}, 8'h00);
    check_eq("rdy_valid", {7'b0, valid}, 8'h00);
    check_eq("rdy_a", {2'b0, a}, 8'h3B);
    check_eq("rdy_b", {2'b0, b}, 8'h05);
    check_eq("rdy_cmp", {6'b0, comparison}, 8'h01);
    do_press(6'b001100, 1'b1, 1'b0);
    check_eq("ow_a", {2'b0, a}, 8'h0C);
    check_eq("ow_b", {2'b0, b}, 8'h05);
    check_eq("ow_cmp", {6'b0, comparison}, 8'h01);
    check_eq("ow_step", {6'b0, step}, 8'h01);

    // Clear from LOAD_OP.
    do_press(6'b000000, 1'b0, 1'b1);
    check_eq("clr0_step", {6'b0, step}, 8'h00);
    do_press(6'h2A, 1'b1, 1'b0);
    do_press(6'h15, 1'b1, 1'b0);
    check_eq("pre_clr_step", {6'b0, step}, 8'h02);
    check_eq("pre_clr_b", {2'b0, b}, 8'h15);
    do_press(6'h3F, 1'b0, 1'b1);
    check_eq("clr_a", {2'b0, a}, 8'h00);
    check_eq("clr_b", {2'b0, b}, 8'h00);
    check_eq("clr_cmp", {6'b0, comparison}, 8'h00);
    check_eq("clr_valid", {7'b0, valid}, 8'h00);
    check_eq("clr_step", {6'b0, step}, 8'h00);

    // Coincident clear and load: clear wins.
    do_press(6'h2A, 1'b1, 1'b0);
    check_eq("co_pre_a", {2'b0, a}, 8'h2A);
    do_press(6'h11, 1'b1, 1'b1);
    check_eq("co_step", {6'b0, step}, 8'h00);
    check_eq("co_a", {2'b0, a}, 8'h00);
    check_eq("co_b", {2'b0, b}, 8'h00);

    // Bounce: high 2 cycles, low 2 cycles, for 20 cycles.
    sw = 6'h33;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btn_load = ((i % 4) < 2);
    end
    @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("bounce_step", {6'b0, step}, 8'h00);
    check_eq("bounce_a", {2'b0, a}, 8'h00);

    // Held 100 cycles: one advance, latency 7 edges.
    @(negedge clk);
    sw = 6'h24;
    btn_load = 1'b1;
    measure_latency(lat);
    check_eq("held_latency", lat[7:0], 8'd7);
    repeat (100) @(negedge clk);
    check_eq("held_step", {6'b0, step}, 8'h01);
    check_eq("held_a", {2'b0, a}, 8'h24);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("strobe_total", strobe_cnt[7:0], 8'd1);

    // Reset pulse while the load counter sits at 3 of 4.
    @(negedge clk);
    sw = 6'h09;
    btn_load = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_a", {2'b0, a}, 8'h00);
    check_eq("mid_rst_step", {6'b0, step}, 8'h00);
    check_eq("mid_rst_valid", {7'b0, valid}, 8'h00);
    #2;
    rst_n = 1'b1;
    measure_latency(lat);
    check_eq("rst_requal_latency", lat[7:0], 8'd7);
    check_eq("rst_requal_step", {6'b0, step}, 8'h01);
    check_eq("rst_requal_a", {2'b0, a}, 8'h09);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);

    check_eq("strobe_align", strobe_bad[7:0], 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
